// File: rtl/ncl_pkg.sv
// Dual-rail code points shared by the NCL stage and anything decoding its outputs.
// A code is formed as {rail1, rail0}.
package ncl_pkg;

    typedef enum logic [1:0] {
        NCL_NULL    = 2'b00,
        NCL_DATA0   = 2'b01,
        NCL_DATA1   = 2'b10,
        NCL_ILLEGAL = 2'b11
    } ncl_code_e;

    function automatic ncl_code_e ncl_pair(input logic rail1, input logic rail0);
        return ncl_code_e'({rail1, rail0});
    endfunction

endpackage

// File: rtl/ncl_th22_cell.sv
// Clocked 2-of-2 hysteresis cell: sets when both inputs are 1, clears when both are 0.
// RST selects the init value (0 = TH22, 1 = TH22D).
module ncl_th22_cell #(
    parameter logic RST = 1'b0
) (
    input  logic clk,
    input  logic init,
    input  logic a,
    input  logic b,
    output logic q
);

    logic q_q;
    logic q_d;

    // Equality tests fail on X, so an unknown input falls through to hold.
    always_comb begin
        q_d = q_q;
        if (a == 1'b1 && b == 1'b1) begin
            q_d = 1'b1;
        end else if (a == 1'b0 && b == 1'b0) begin
            q_d = 1'b0;
        end
    end

    always_ff @(posedge clk or posedge init) begin
        if (init) begin
            q_q <= RST;
        end else begin
            q_q <= q_d;
        end
    end

    assign q = q_q;

endmodule

// File: rtl/ncl_th_stage.sv
// One dual-rail NCL register stage: a TH22/TH22D cell per rail, gated by the shared en,
// with per-bit TH12 completion and whole-word DATA/NULL/illegal detection.
module ncl_th_stage
    import ncl_pkg::*;
#(
    parameter int               WIDTH     = 1,
    parameter logic [WIDTH-1:0] RST_RAIL0 = {WIDTH{1'b0}},
    parameter logic [WIDTH-1:0] RST_RAIL1 = {WIDTH{1'b0}}
) (
    input  logic             clk,
    input  logic             init,
    input  logic [WIDTH-1:0] a0,
    input  logic [WIDTH-1:0] a1,
    input  logic             en,
    output logic [WIDTH-1:0] z0,
    output logic [WIDTH-1:0] z1,
    output logic [WIDTH-1:0] comp,
    output logic             comp_all,
    output logic             null_all,
    output logic [WIDTH-1:0] invalid
);

    for (genvar i = 0; i < WIDTH; i++) begin : g_bit
        ncl_code_e code;

        ncl_th22_cell #(.RST(RST_RAIL0[i])) u_rail0 (
            .clk  (clk),
            .init (init),
            .a    (a0[i]),
            .b    (en),
            .q    (z0[i])
        );

        ncl_th22_cell #(.RST(RST_RAIL1[i])) u_rail1 (
            .clk  (clk),
            .init (init),
            .a    (a1[i]),
            .b    (en),
            .q    (z1[i])
        );

        // TH12 completion; an illegal code still counts as complete.
        assign code       = ncl_pair(z1[i], z0[i]);
        assign comp[i]    = (code != NCL_NULL);
        assign invalid[i] = (code == NCL_ILLEGAL);
    end

    assign comp_all = &comp;
    assign null_all = ~|comp;

endmodule

// File: tb/tb_ncl_th_stage.sv
// Scoreboard bench for ncl_th_stage (WIDTH=2, rail0 bit0 is a TH22D cell).
// Stimulus pushes expected outputs from a rule-level model; a monitor pops and compares.
module tb_ncl_th_stage;

    localparam int         W  = 2;
    localparam logic [1:0] R0 = 2'b01;
    localparam logic [1:0] R1 = 2'b00;

    logic         clk;
    logic         init;
    logic [W-1:0] a0, a1;
    logic         en;
    logic [W-1:0] z0, z1, comp, invalid;
    logic         comp_all, null_all;

    ncl_th_stage #(.WIDTH(W), .RST_RAIL0(R0), .RST_RAIL1(R1)) dut (
        .clk      (clk),
        .init     (init),
        .a0       (a0),
        .a1       (a1),
        .en       (en),
        .z0       (z0),
        .z1       (z1),
        .comp     (comp),
        .comp_all (comp_all),
        .null_all (null_all),
        .invalid  (invalid)
    );

    typedef struct {
        logic [W-1:0] z0;
        logic [W-1:0] z1;
        logic [W-1:0] comp;
        logic         comp_all;
        logic         null_all;
        logic [W-1:0] invalid;
        string        name;
    } exp_t;

    exp_t   exp_q[$];
    event   push_ev;
    int     checks   = 0;
    int     failures = 0;
    int     pushed   = 0;
    logic [W-1:0] m0, m1;

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Model: a rail adopts en's value when its input agrees with en, otherwise keeps its value.
    task automatic model_reset();
        m0 = R0;
        m1 = R1;
    endtask

    task automatic model_edge();
        if (init) begin
            model_reset();
        end else begin
            for (int i = 0; i < W; i++) begin
                if (a0[i] == en) m0[i] = en;
                if (a1[i] == en) m1[i] = en;
            end
        end
    endtask

    task automatic push(input string nm);
        exp_t e;
        int   ndata;
        ndata = 0;
        e.z0 = m0;
        e.z1 = m1;
        for (int i = 0; i < W; i++) begin
            e.comp[i]    = m0[i] || m1[i];
            e.invalid[i] = m0[i] && m1[i];
            if (m0[i] || m1[i]) ndata++;
        end
        e.comp_all = (ndata == W);
        e.null_all = (ndata == 0);
        e.name     = nm;
        exp_q.push_back(e);
        pushed++;
        -> push_ev;
    endtask

    task automatic drive(input logic [W-1:0] x0, input logic [W-1:0] x1, input logic e);
        @(negedge clk);
        a0 = x0;
        a1 = x1;
        en = e;
    endtask

    task automatic tick(input string nm);
        @(posedge clk);
        model_edge();
        #1;
        push(nm);
    endtask

    task automatic check_now(input string nm);
        #1;
        push(nm);
    endtask

    initial begin : monitor
        exp_t e;
        forever begin
            @(push_ev);
            while (exp_q.size() > 0) begin
                e = exp_q.pop_front();
                checks++;
                if ({z0, z1, comp, comp_all, null_all, invalid} !==
                    {e.z0, e.z1, e.comp, e.comp_all, e.null_all, e.invalid}) begin
                    failures++;
                    $display("FAIL %s: got z0=%b z1=%b comp=%b comp_all=%b null_all=%b invalid=%b, want z0=%b z1=%b comp=%b comp_all=%b null_all=%b invalid=%b",
                             e.name, z0, z1, comp, comp_all, null_all, invalid,
                             e.z0, e.z1, e.comp, e.comp_all, e.null_all, e.invalid);
                end
            end
        end
    end

    initial begin : watchdog
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "timeout");
    end

    initial begin : stimulus
        init = 1'b0;
        a0   = '0;
        a1   = '0;
        en   = 1'b0;
        model_reset();

        // Init pulse that completes before the first clock edge.
        #2 init = 1'b1;
        model_reset();
        check_now("reset_async");
        #1 init = 1'b0;
        a0 = 2'b10;
        a1 = 2'b01;
        en = 1'b1;
        tick("first_edge");

        // Full NULL -> DATA -> hold -> NULL cycle.
        drive(2'b00, 2'b00, 1'b0);
        tick("clear_to_null");
        drive(2'b01, 2'b10, 1'b1);
        tick("null_to_data");
        drive(2'b00, 2'b00, 1'b1);
        tick("data_hold");
        drive(2'b00, 2'b00, 1'b0);
        tick("data_to_null");

        // Hysteresis on a set cell.
        drive(2'b11, 2'b00, 1'b1);
        tick("set_rail0");
        repeat (5) begin
            drive(2'b00, 2'b00, 1'b1);
            tick("hyst_in0_en1");
        end
        drive(2'b11, 2'b00, 1'b0);
        tick("hyst_in1_en0");

        // Async init between edges, held across qualifying edges, then released.
        drive(2'b11, 2'b00, 1'b1);
        #2 init = 1'b1;
        model_reset();
        check_now("init_mid_cycle");
        repeat (3) tick("init_held");
        @(negedge clk);
        init = 1'b0;
        check_now("init_released");
        tick("first_edge_after_init");

        // init rising together with a qualifying clock edge.
        drive(2'b00, 2'b00, 1'b0);
        tick("clear_before_race");
        drive(2'b11, 2'b01, 1'b1);
        @(posedge clk);
        init = 1'b1;
        model_reset();
        check_now("init_vs_clk_edge");
        @(negedge clk);
        init = 1'b0;
        check_now("race_released");
        tick("race_followup_edge");

        // Randomized traffic with occasional mid-cycle init pulses.
        for (int n = 0; n < 80; n++) begin
            drive(W'($urandom), W'($urandom), 1'($urandom));
            if ($urandom_range(0, 9) == 0) begin
                #2 init = 1'b1;
                model_reset();
                check_now("rand_init");
                init = 1'b0;
            end
            tick("rand_edge");
        end

        #5;
        if (exp_q.size() != 0 || pushed != checks) begin
            failures++;
            $display("FAIL scoreboard_drain: compared %0d of %0d expected entries", checks, pushed);
        end
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/ncl_th_stage.md
Name: ncl_th_stage

Overview:
- Clocked behavioural model of a bank of NCL threshold gates forming one dual-rail pipeline register stage.
- Each rail passes through a 2-of-2 hysteresis gate: TH22, or TH22D where it must reset to asserted.
- Each dual-rail output pair is reduced by a 1-of-2 gate (TH12) into a completion signal.
- Sits between ring/pipeline stages; its completion output drives the upstream stage's enable logic.

Parameters:
- WIDTH, 1, number of dual-rail bits in the stage.
- RST_RAIL0, {WIDTH{1'b0}}, per-bit reset value of rail-0 cells; a 1 makes that cell a TH22D, a 0 makes it a TH22.
- RST_RAIL1, {WIDTH{1'b0}}, per-bit reset value of rail-1 cells, same meaning as RST_RAIL0.

Ports:
- clk  input  1  single clock; all state updates on its rising edge.
- init  input  1  reset, asynchronous, active-high (already decided); sets every cell to its RST_* value.
- a0  input  WIDTH  rail-0 data inputs.
- a1  input  WIDTH  rail-1 data inputs.
- en  input  1  shared second input of every TH22/TH22D cell; it is the stage request/acknowledge.
- z0  output  WIDTH  rail-0 cell states.
- z1  output  WIDTH  rail-1 cell states.
- comp  output  WIDTH  per-bit TH12 completion: z0[i] OR z1[i].
- comp_all  output  1  AND of all comp bits; the whole word is DATA.
- null_all  output  1  NOR of all comp bits; the whole word is NULL.
- invalid  output  WIDTH  z0[i] AND z1[i]; illegal dual-rail code.

Behaviour:
- Each rail of each bit is an independent cell with one state bit q.
- On rising clk edge with init=0:
  - input=1 and en=1 -> q becomes 1.
  - input=0 and en=0 -> q becomes 0.
  - Any other combination -> q holds (hysteresis).
- Output latency: z0/z1 equal q, registered, so they change one clk edge after qualifying inputs.
- comp, comp_all, null_all and invalid are purely combinational from z0/z1 and add no extra latency.
- init=1 forces q to its RST_* bit immediately, with no clock needed.
  - TH22 cells reset to 0; TH22D cells reset to 1.
- init dominates a simultaneous clk edge.
- After init falls, the first update happens on the next rising clk edge.
- Reset mid-operation discards in-flight state; no partial update survives.
- Cells never evaluate X as asserted: X on an input or en counts as "not both equal", so q holds.
- No other state exists: no FSM, no counters.
- If both RST_* bits of a bit are 1, the block still resets as specified; invalid is then 1 for that bit until cleared.

Decomposition:
- Shared package ncl_pkg holds:
  - NCL_NULL = 2'b00
  - NCL_DATA0 = 2'b01 (z1,z0)
  - NCL_DATA1 = 2'b10
  - NCL_ILLEGAL = 2'b11
- One sub-module, ncl_th22_cell:
  - ports clk, init, a, b, q; parameter RST (0 = TH22, 1 = TH22D).
  - Instantiated 2*WIDTH times via generate.
- TH12 and the reductions stay inline in ncl_th_stage.

Test Plan:
- WIDTH=2, RST_RAIL0=2'b01, RST_RAIL1=0; pulse init=1 with no clk edge -> z0=01, z1=00, comp=01, comp_all=0, null_all=0 immediately.
- After reset, a0=2'b10, a1=2'b01, en=1, one clk edge -> z0=11, z1=01, invalid=01 (bit0 rail0 held from reset, rail1 set).
- Normal cycle from NULL (RST=0): a0=01, a1=10, en=1, edge -> z0=01, z1=10, comp=11, comp_all=1. Then a0=a1=0 with en=1, edge -> outputs hold. Then en=0, edge -> all z=0, null_all=1.
- Hysteresis: q=1, apply input=0 and en=1 for 5 edges -> q stays 1. Apply input=1 and en=0 -> q stays 1.
- Async reset mid-operation: z0=11, assert init between clk edges -> z0 returns to RST_RAIL0 within the same timestep. Hold init across 3 edges with a0=11, en=1 -> no change. Release init -> update on next edge.
- Simultaneous init rise and clk edge with qualifying inputs -> reset value wins.
